// File: rtl/pipe_alu_fwd_if.sv
// pipe_alu_fwd_if
//   Bundles the instruction handshake, the ALU result outputs and the
//   memory read-back port of pipe_alu_fwd.
//   master : instruction source (drives in_valid/rs1/rs2/rd/func/addr/mem_raddr)
//   slave  : the pipeline (drives in_ready/z/z_valid/mem_rdata)
interface pipe_alu_fwd_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] z;
  logic              z_valid;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    input  in_ready, z, z_valid, mem_rdata
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    output in_ready, z, z_valid, mem_rdata
  );
endinterface

// File: rtl/pipe_alu_fwd.sv
// pipe_alu_fwd
//   Three-stage pipeline: S1 operand fetch from regbank, S2 ALU,
//   S3 write-back of the result to regbank[rd] and mem[addr].
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - pipe_alu_fwd_if.slave: in_valid/in_ready handshake, rs1/rs2/rd,
//            func, addr, registered result z/z_valid, mem_raddr -> mem_rdata
//            (registered, 1-cycle latency)
//   Build option:
//     PIPE_FWD_EN defined   : RAW hazards resolved by bypassing the S1 ALU
//                             output and the S2 result into operand fetch.
//     PIPE_FWD_EN undefined : no bypass; in_ready drops while a source register
//                             matches the rd of a valid S1/S2 instruction.
//   regbank and mem are not cleared by reset and may be preloaded
//   hierarchically.
module pipe_alu_fwd #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input logic          clk,
  input logic          rst,
  pipe_alu_fwd_if.slave bus
);

  logic [DATA_W-1:0] regbank [0:2**REG_AW-1];
  logic [DATA_W-1:0] mem     [0:2**MEM_AW-1];

  function automatic logic [DATA_W-1:0] alu_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [3:0]        f);
    logic [DATA_W-1:0] r;
    r = '0;
    case (f)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = a;
      4'd4:    r = b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = ~a;
      4'd9:    r = ~b;
      4'd10:   r = a >> 1;
      4'd11:   r = a << 1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // control
  logic              r_rdy;
  logic              r_vld_p1;
  logic              r_vld_p2;
  // S1 data
  logic [DATA_W-1:0] r_opa_p1;
  logic [DATA_W-1:0] r_opb_p1;
  logic [3:0]        r_func_p1;
  logic [REG_AW-1:0] r_rd_p1;
  logic [MEM_AW-1:0] r_addr_p1;
  // S2 data
  logic [DATA_W-1:0] r_z_p2;
  logic [REG_AW-1:0] r_rd_p2;
  logic [MEM_AW-1:0] r_addr_p2;
  logic [DATA_W-1:0] r_mem_rdata;

  logic [DATA_W-1:0] w_alu_p1;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_stall;
  logic              w_in_ready;
  logic              w_accept;

  assign w_alu_p1 = alu_op(r_opa_p1, r_opb_p1, r_func_p1);

`ifdef PIPE_FWD_EN
  // Youngest producer is applied last so it takes priority over S2 and regbank.
  always_comb begin
    w_opa   = regbank[bus.rs1];
    w_opb   = regbank[bus.rs2];
    w_stall = 1'b0;
    if (r_vld_p2 && (r_rd_p2 == bus.rs1)) w_opa = r_z_p2;
    if (r_vld_p2 && (r_rd_p2 == bus.rs2)) w_opb = r_z_p2;
    if (r_vld_p1 && (r_rd_p1 == bus.rs1)) w_opa = w_alu_p1;
    if (r_vld_p1 && (r_rd_p1 == bus.rs2)) w_opb = w_alu_p1;
  end
`else
  // The S2 producer writes regbank on the same edge the consumer would read
  // it, so a match in S2 must stall as well as a match in S1.
  always_comb begin
    w_opa   = regbank[bus.rs1];
    w_opb   = regbank[bus.rs2];
    w_stall = bus.in_valid &&
              ((r_vld_p1 && ((r_rd_p1 == bus.rs1) || (r_rd_p1 == bus.rs2))) ||
               (r_vld_p2 && ((r_rd_p2 == bus.rs1) || (r_rd_p2 == bus.rs2))));
  end
`endif

  assign w_in_ready = r_rdy && !w_stall;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy       <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_z_p2      <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_rdy       <= 1'b1;
      r_vld_p1    <= w_accept;
      r_vld_p2    <= r_vld_p1;
      if (r_vld_p1) r_z_p2 <= w_alu_p1;
      r_mem_rdata <= mem[bus.mem_raddr];
    end
  end

  // S1: operand fetch
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opa_p1  <= w_opa;
      r_opb_p1  <= w_opb;
      r_func_p1 <= bus.func;
      r_rd_p1   <= bus.rd;
      r_addr_p1 <= bus.addr;
    end
  end

  // S2: ALU result register
  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      r_rd_p2   <= r_rd_p1;
      r_addr_p2 <= r_addr_p1;
    end
  end

  // S3: write-back; rst gating guards an edge coinciding with reset assertion
  always_ff @(posedge clk) begin
    if (r_vld_p2 && !rst) begin
      regbank[r_rd_p2] <= r_z_p2;
      mem[r_addr_p2]   <= r_z_p2;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.z         = r_z_p2;
  assign bus.z_valid   = r_vld_p2;
  assign bus.mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_pipe_alu_fwd.sv
module tb_pipe_alu_fwd;
  localparam int DW = 16;
  localparam int RA = 4;
  localparam int MA = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_alu_fwd_if #(.DATA_W(DW), .REG_AW(RA), .MEM_AW(MA)) bus ();

  pipe_alu_fwd #(.DATA_W(DW), .REG_AW(RA), .MEM_AW(MA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] reg_m [0:2**RA-1];
  logic [DW-1:0] mem_m [0:2**MA-1];
  logic [DW-1:0] reg_s [0:2**RA-1];
  logic [DW-1:0] mem_s [0:2**MA-1];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    int rs1; int rs2; int rd; int func; int addr; logic [DW-1:0] z;
  } vec_t;
  vec_t tbl [13];

  // Reference: plain integer arithmetic modulo 2**DW.
  function automatic logic [DW-1:0] ref_alu(input longint a, input longint b, input int f);
    longint m, r;
    m = longint'(1) << DW;
    case (f)
      0: r = a + b;
      1: r = a - b + m;
      2: r = a * b;
      3: r = a;
      4: r = b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = m - 1 - a;
      9: r = m - 1 - b;
      10: r = a / 2;
      11: r = a * 2;
      default: r = 0;
    endcase
    r = r % m;
    return r[DW-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: each cycle z_valid is high carries one new result in order.
  always @(negedge clk) begin
    if (!rst && bus.z_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL z_unexpected: got %0h expected no result", bus.z);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("z_stream", bus.z, e);
      end
    end
  end

  task automatic preload();
    for (int k = 0; k < 2**RA; k++) begin
      dut.regbank[k] = DW'(k);
      reg_m[k] = DW'(k);
    end
    for (int k = 0; k < 2**MA; k++) begin
      dut.mem[k] = '0;
      mem_m[k] = '0;
    end
  endtask

  task automatic issue(input int a, input int b, input int d, input int f,
                       input int ad, output int stalls);
    bit ok;
    logic [DW-1:0] r;
    ok = 0;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.rs1 = RA'(a); bus.rs2 = RA'(b); bus.rd = RA'(d);
    bus.func = 4'(f); bus.addr = MA'(ad);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1; break; end
      stalls++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b expected 1", bus.in_ready);
    end else begin
      r = ref_alu(longint'(reg_m[a]), longint'(reg_m[b]), f);
      exp_q.push_back(r);
      reg_m[d]  = r;
      mem_m[ad] = r;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    logic zv1, zv2, zv3;

    tbl[0]  = '{3, 5, 10, 0, 125, 16'd8};
    tbl[1]  = '{3, 8, 12, 2, 60, 16'd24};
    tbl[2]  = '{7, 0, 13, 11, 61, 16'd14};
    tbl[3]  = '{7, 0, 13, 10, 62, 16'd3};
    tbl[4]  = '{3, 5, 15, 13, 63, 16'd0};
    tbl[5]  = '{6, 5, 11, 5, 64, 16'd4};
    tbl[6]  = '{6, 5, 11, 6, 65, 16'd7};
    tbl[7]  = '{6, 5, 11, 7, 66, 16'd3};
    tbl[8]  = '{2, 0, 9, 8, 67, 16'hFFFD};
    tbl[9]  = '{0, 4, 9, 9, 68, 16'hFFFB};
    tbl[10] = '{6, 2, 11, 3, 69, 16'd6};
    tbl[11] = '{6, 2, 11, 4, 70, 16'd2};
    tbl[12] = '{3, 5, 9, 1, 71, 16'hFFFE};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
    bus.func = '0; bus.addr = '0; bus.mem_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", bus.z, 0);
    check("rst_z_valid", bus.z_valid, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("release_in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk); #1;
    check("release_in_ready_after_edge", bus.in_ready, 1);

    // Table-driven ALU vectors
    preload();
    foreach (tbl[i]) begin
      issue(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].func, tbl[i].addr, st);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_z", i), bus.z, tbl[i].z);
      check($sformatf("tbl%0d_z_valid", i), bus.z_valid, 1);
    end
    drain();
    check("wb_regbank10", dut.regbank[10], 8);
    check("wb_mem125", dut.mem[125], 8);
    bus.mem_raddr = 8'd125;
    @(posedge clk); #1;
    check("mem_rdata125", bus.mem_rdata, 8);

    // Back-to-back dependent pair
    preload();
    issue(3, 5, 10, 0, 125, st);
    issue(10, 5, 14, 1, 127, st);
`ifdef PIPE_FWD_EN
    check("b2b_stall_cycles", st, 0);
`else
    check("b2b_stall_cycles", st, 2);
`endif
    drain();
    check("b2b_regbank14", dut.regbank[14], 3);
    check("b2b_mem127", dut.mem[127], 3);

    // Wrap-around
    preload();
    dut.regbank[1] = 16'hFFFF;
    reg_m[1] = 16'hFFFF;
    issue(1, 1, 2, 0, 80, st);
    @(posedge clk); #1;
    check("wrap_add", bus.z, 16'hFFFE);
    issue(3, 5, 4, 1, 81, st);
    @(posedge clk); #1;
    check("wrap_sub", bus.z, 16'hFFFE);
    drain();

    // Bubble between two instructions
    preload();
    issue(3, 5, 6, 0, 90, st);
    bus.in_valid = 1'b0; bus.addr = 8'd200; bus.rd = 4'd7;
    @(posedge clk); #1;
    zv1 = bus.z_valid;
    issue(2, 4, 9, 0, 91, st);
    zv2 = bus.z_valid;
    @(posedge clk); #1;
    zv3 = bus.z_valid;
    check("bubble_zv1", zv1, 1);
    check("bubble_zv2", zv2, 0);
    check("bubble_zv3", zv3, 1);
    drain();
    check("bubble_mem200", dut.mem[200], mem_m[200]);
    check("bubble_regbank7", dut.regbank[7], reg_m[7]);

    // Reset with two instructions in flight
    preload();
    for (int k = 0; k < 2**RA; k++) reg_s[k] = reg_m[k];
    for (int k = 0; k < 2**MA; k++) mem_s[k] = mem_m[k];
    dut.mem[50] = 16'h1234; mem_s[50] = 16'h1234;
    bus.mem_raddr = 8'd50;
    issue(3, 5, 10, 0, 125, st);
    issue(2, 4, 14, 0, 127, st);
    rst = 1'b1;
    #1;
    check("midrst_z", bus.z, 0);
    check("midrst_z_valid", bus.z_valid, 0);
    check("midrst_mem_rdata", bus.mem_rdata, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2**RA; k++) reg_m[k] = reg_s[k];
    for (int k = 0; k < 2**MA; k++) mem_m[k] = mem_s[k];
    @(posedge clk); #1;
    drain();
    check("midrst_regbank10", dut.regbank[10], 10);
    check("midrst_regbank14", dut.regbank[14], 14);
    check("midrst_mem125", dut.mem[125], 0);
    check("midrst_mem127", dut.mem[127], 0);
    issue(3, 5, 10, 0, 125, st);
    drain();
    check("post_rst_regbank10", dut.regbank[10], 8);
    check("post_rst_mem125", dut.mem[125], 8);

    // Randomized hazard-heavy stream against the sequential model
    preload();
    for (int n = 0; n < 150; n++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 15), st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    for (int k = 0; k < 2**RA; k++)
      check($sformatf("rand_regbank%0d", k), dut.regbank[k], reg_m[k]);
    for (int k = 0; k < 16; k++)
      check($sformatf("rand_mem%0d", k), dut.mem[k], mem_m[k]);
    check("results_outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_alu_fwd.md
Name: pipe_alu_fwd

Overview:
- Parametrised single-clock successor of the team's 3-stage register-bank/ALU/memory pipeline.
- Three stages:
  - S1: operand fetch from the register bank.
  - S2: ALU.
  - S3: write-back of the result to the register bank and data memory.
- Adds a valid/ready handshake, RAW-hazard handling and a registered memory read-back port.
- Feeds the datapath experiments under the pipeline directory; a bench drives it directly.

Parameters:
- DATA_W, 16, width of register bank entries, ALU operands, result and memory words.
- REG_AW, 4, register-bank address width (2**REG_AW registers).
- MEM_AW, 8, data-memory address width (2**MEM_AW words).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  instruction present on rs1/rs2/rd/func/addr.
- in_ready  out  1  block accepts the instruction this cycle.
- rs1  in  REG_AW  source register A.
- rs2  in  REG_AW  source register B.
- rd  in  REG_AW  destination register.
- func  in  4  ALU operation code.
- addr  in  MEM_AW  memory address for the result store.
- z  out  DATA_W  registered S2 ALU result.
- z_valid  out  1  z holds a valid result this cycle.
- mem_raddr  in  MEM_AW  read-back address.
- mem_rdata  out  DATA_W  mem[mem_raddr], registered, 1-cycle latency.

Behaviour:
- Storage:
  - Arrays are named regbank[0:2**REG_AW-1] and mem[0:2**MEM_AW-1]; both are hierarchically preloadable by benches.
  - Neither array is cleared by reset.
- Accept occurs on a rising edge with in_valid && in_ready.
- Timing, for an instruction accepted at edge E0:
  - E0: S1 captures opA=regbank[rs1], opB=regbank[rs2] (forwarded if needed), plus func, rd, addr and s1_valid.
  - E1: S2 captures z = ALU(opA, opB, func) and z_valid=1.
  - E2: S3 writes regbank[rd]=z and mem[addr]=z.
  - z/z_valid therefore appear one edge after accept; architectural state updates two edges after accept.
- Bubbles:
  - Cycles with no accept insert a bubble: s1_valid=0, which gives z_valid=0 one edge later.
  - A bubble performs no write; z holds its last value.
- ALU (result truncated to DATA_W bits, unsigned wrap):
  - 0 A+B
  - 1 A-B
  - 2 A*B (low DATA_W bits)
  - 3 A
  - 4 B
  - 5 A&B
  - 6 A|B
  - 7 A^B
  - 8 ~A
  - 9 ~B
  - 10 A>>1 (logical)
  - 11 A<<1
  - 12-15 produce 0
- RAW hazards with forwarding (see Optional Feature):
  - Operand read priority: S1 in-flight producer (combinational ALU output) > S2 producer (z) > regbank.
  - A match requires the producer's valid=1 and its rd equal to the operand's source register.
  - in_ready is held at 1.
- Same-edge read/write of the same register: the forwarded value wins, so the new value is always used.
- Two in-flight writes to the same rd: the younger instruction overwrites the older in program order.
- mem_rdata is registered and reflects a same-edge S3 write one cycle later (read-before-write at the edge).
- Reset (asserted at any time):
  - Outputs: z=0, z_valid=0, mem_rdata=0, in_ready=0.
  - Internal: all pipeline valids are cleared.
  - In-flight instructions are discarded and perform no regbank/mem writes.
  - in_ready returns to 1 on the first clk edge after rst deasserts.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: forwarding as described above; in_ready=1 except during reset.
- Undefined: no bypass paths; an interlock replaces them.
  - in_ready=0 whenever in_valid=1 and rs1 or rs2 equals the rd of a valid instruction in S1 or S2.
  - A dependent instruction therefore stalls until its producer has written the regbank at S3, i.e. up to 2 cycles.
  - Operands are always read from regbank.
  - Results must be identical to the forwarding build; only timing differs.

Test Plan:
- regbank[k]=k preloaded; issue rs1=3,rs2=5,rd=10,func=0,addr=125 -> z=8 with z_valid one edge after accept; regbank[10]=8 and mem[125]=8 after the second edge; mem_raddr=125 -> mem_rdata=8.
- Back-to-back: (3+5->r10), then next cycle rs1=10,rs2=5,rd=14,func=1,addr=127 -> z=3, mem[127]=3.
  - With PIPE_FWD_EN: no stall.
  - Without: in_ready low for 2 cycles, same final values.
- func=2 rs1=3,rs2=8,rd=12 -> z=24; func=11 rs1=7 -> z=14; func=10 rs1=7 -> z=3; func=13 -> z=0.
- Wrap: regbank[1]=16'hFFFF, func=0 rs1=1,rs2=1 -> z=16'hFFFE; func=1 rs1=3,rs2=5 -> z=16'hFFFE.
- Bubble: in_valid low for one cycle between two instructions -> z_valid shows 1,0,1; no spurious mem write at the target address of the bubble cycle.
- Reset mid-flight: rst high for one cycle while two instructions (rd=10/addr=125, rd=14/addr=127) are in S1/S2 -> z=0, z_valid=0 immediately; regbank[10], regbank[14], mem[125], mem[127] unchanged; next instruction after release completes normally.
